riscv_hazard_ctrl: RTL
======================

# riscv_hazard_ctrl

Pipeline hazard controller for the 5-stage RISC-V core (IF, ID, EX, MEM, WB). It keeps a shadow pipeline of in-flight destination tags and produces these controls every cycle:
- load-use stalls;
- EX-stage forwarding selects;
- ID-stage write-back bypass;
- taken-BEQ flushes.

It sits beside the datapath, reads only the IF/ID instruction register and the EX branch outcome, and owns two saturating event counters.

## Interface
- CNT_W, 32, width of performance counters
- clock  in  1  rising-edge clock
- reset_n  in  1  synchronous, active-low reset
- ifid_ir  in  32  instruction currently held in IF/ID
- branch_taken  in  1  EX-stage BEQ compare result (IDEXA == IDEXB); meaningful only when EX slot holds BEQ
- stall_pc  out  1  hold PC this edge
- stall_ifid  out  1  hold IF/ID this edge
- bubble_idex  out  1  load NOP into ID/EX this edge
- flush_ifid  out  1  load NOP into IF/ID this edge
- id_byp_a / id_byp_b  out  1  ID must take MEMWBValue instead of Regs[rs1]/Regs[rs2]
- fwd_a / fwd_b  out  2  EX ALU input select: 00 ID/EX register, 01 MEMWBValue, 10 EXMEMALUOut (11 never driven)
- stall_cycles  out  CNT_W  load-use stall cycles since reset
- flush_events  out  CNT_W  taken-branch flushes since reset

## Operation
- **Decode of ifid_ir**
  - rs1 = [19:15], rs2 = [24:20], rd = [11:7].
  - uses_rs1 for LD, SD, BEQ, ALUop.
  - uses_rs2 for SD, BEQ, ALUop.
  - writes = (LD or ALUop) and rd != 0.
  - is_load = LD.
  - Unknown opcodes use and write nothing.
- **Shadow slots**
  - Slots are EX, MEM, WB. Each holds {valid, rd, writes, is_load, is_beq}.
  - Each edge: WB<=MEM, MEM<=EX, and EX<=decoded ifid_ir.
  - EX loads an invalid bubble instead when bubble_idex=1.
- **Branch flush**
  - Condition: EX valid, is_beq, and branch_taken.
  - Action: flush_ifid=1 and bubble_idex=1; flush_events increments.
  - stall_pc=0, so the datapath loads its redirect target.
- **Load-use stall**
  - Condition: EX valid, is_load, writes, and (uses_rs1 and rs1==EX.rd or uses_rs2 and rs2==EX.rd).
  - Action: stall_pc=stall_ifid=bubble_idex=1; stall_cycles increments.
- **Priority**: branch flush beats load-use stall. With both true, only the flush outputs assert and only flush_events counts.
- **Forwarding**
  - Computed for the ID instruction and registered into fwd_a/fwd_b at the same edge it enters ID/EX.
  - Per operand: 10 if EX slot valid, writes, and rd matches; else 01 if MEM slot valid, writes, and rd matches; else 00.
  - An operand with its uses_* flag clear gets 00.
  - When bubble_idex=1, fwd_a/fwd_b register 00.
- **ID bypass**
  - id_byp_x=1 when WB slot is valid, writes, and rd == rs_x.
  - Needed because the register write and the ID read share one edge.
- **x0**: rd==0 never matches anything, because writes is already 0.
- **Counters**: saturate at 2^CNT_W-1; no wrap.

## Timing
- stall_pc, stall_ifid, bubble_idex, flush_ifid, and id_byp_* are combinational from slot state, ifid_ir, and branch_taken, and are valid within the same cycle.
- fwd_a/fwd_b are registered: valid during the cycle the consuming instruction is in EX.
- A load-use stall lasts exactly 1 cycle. On the next cycle the load sits in the MEM slot and the consumer gets fwd 01.
- A taken branch costs exactly 2 bubbles: the IF/ID flush plus the ID/EX bubble.
- **Reset** (reset_n=0 at an edge):
  - all slots invalid; fwd_a/fwd_b=00; counters=0.
  - Combinational outputs are forced to 0 while reset_n=0.
  - Reset mid-stall or mid-flush abandons the event. The first cycle after reset behaves as an empty pipeline.
- Simultaneous EX and MEM match on the same operand resolves to 10 (youngest producer).

## Structure
- Package riscv_pipe_pkg holds:
  - opcode constants LD=7'b000_0011, SD=7'b010_0011, BEQ=7'b110_0011, ALUop=7'b001_0011;
  - NOP=32'h0000_0013;
  - fwd_sel_t enum (FWD_REG, FWD_MEMWB, FWD_EXMEM);
  - slot_t struct.
- One sub-module, riscv_dep_decode: combinational ifid_ir -> {rs1, rs2, rd, uses_rs1, uses_rs2, writes, is_load, is_beq}.
- Slot registers, comparators, and counters live in the top module.

## Test plan
- Load then dependent ALU (LD x5 behind ALUop x6←x5+x7):
  - stall_pc/stall_ifid/bubble_idex high for exactly 1 cycle, then fwd_a=01.
  - stall_cycles=1.
- Back-to-back ALU dependency (x3←x1+x2, then x4←x3+x3): no stall; fwd_a=fwd_b=10 in the consumer's EX cycle.
- Producer 3 instructions ahead (x8 written, two NOPs, then read x8): id_byp_a=1 in consumer's ID cycle; fwd_a=00.
- Taken BEQ with branch_taken=1, plus a simultaneous load-use condition in ID:
  - flush_ifid=bubble_idex=1 and stall_pc=0;
  - flush_events=1, stall_cycles unchanged.
- Writes to x0 (ALUop rd=0 followed by a read of x0): no forwarding, bypass, or stall at any stage.
- Counter and reset behaviour:
  - Preload stall_cycles to 2^32-2 via force, then trigger 3 load-use stalls: counter holds 2^32-1.
  - Assert reset_n=0 during a stall: next cycle all outputs 0 and counters 0.

Source files
------------

// File: rtl/riscv_pipe_pkg.sv
// Shared types and constants for the RISC-V 5-stage pipeline hazard logic.
package riscv_pipe_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned REG_W = 5;
    localparam int unsigned OPC_W = 7;

    localparam logic [OPC_W-1:0] LD    = 7'b000_0011;
    localparam logic [OPC_W-1:0] SD    = 7'b010_0011;
    localparam logic [OPC_W-1:0] BEQ   = 7'b110_0011;
    localparam logic [OPC_W-1:0] ALUop = 7'b001_0011;

    localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        FWD_REG   = 2'b00,
        FWD_MEMWB = 2'b01,
        FWD_EXMEM = 2'b10
    } fwd_sel_t;

    // Destination tag carried by one shadow pipeline slot
    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             writes;
        logic             is_load;
        logic             is_beq;
    } slot_t;

endpackage

// File: rtl/riscv_dep_decode.sv
// Extracts register dependencies and class flags from the IF/ID instruction.
module riscv_dep_decode
    import riscv_pipe_pkg::*;
(
    input  logic [XLEN-1:0]  i_ir,
    output logic [REG_W-1:0] o_rs1,
    output logic [REG_W-1:0] o_rs2,
    output logic [REG_W-1:0] o_rd,
    output logic             o_uses_rs1,
    output logic             o_uses_rs2,
    output logic             o_writes,
    output logic             o_is_load,
    output logic             o_is_beq
);

    logic [OPC_W-1:0] w_opc;
    logic             w_is_ld;
    logic             w_is_sd;
    logic             w_is_beq;
    logic             w_is_alu;
    logic             w_unused_bits;

    assign w_opc    = i_ir[OPC_W-1:0];
    assign w_is_ld  = (w_opc == LD);
    assign w_is_sd  = (w_opc == SD);
    assign w_is_beq = (w_opc == BEQ);
    assign w_is_alu = (w_opc == ALUop);

    assign o_rs1 = i_ir[19:15];
    assign o_rs2 = i_ir[24:20];
    assign o_rd  = i_ir[11:7];

    // Unknown opcodes fall through with every flag low
    assign o_uses_rs1 = w_is_ld | w_is_sd | w_is_beq | w_is_alu;
    assign o_uses_rs2 = w_is_sd | w_is_beq | w_is_alu;
    assign o_writes   = (w_is_ld | w_is_alu) & (o_rd != REG_W'(0));
    assign o_is_load  = w_is_ld;
    assign o_is_beq   = w_is_beq;

    assign w_unused_bits = ^{i_ir[31:25], i_ir[14:12]};

endmodule

// File: rtl/riscv_hazard_ctrl.sv
// Hazard controller: shadow tag pipeline, load-use stall, forwarding, ID bypass,
// taken-branch flush and saturating event counters.
module riscv_hazard_ctrl
    import riscv_pipe_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [XLEN-1:0]  ifid_ir,
    input  logic             branch_taken,
    output logic             stall_pc,
    output logic             stall_ifid,
    output logic             bubble_idex,
    output logic             flush_ifid,
    output logic             id_byp_a,
    output logic             id_byp_b,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    logic [REG_W-1:0] w_rs1;
    logic [REG_W-1:0] w_rs2;
    logic [REG_W-1:0] w_rd;
    logic             w_uses_rs1;
    logic             w_uses_rs2;
    logic             w_writes;
    logic             w_is_load;
    logic             w_is_beq;

    slot_t            r_ex;
    slot_t            r_mem;
    slot_t            r_wb;
    slot_t            w_dec_slot;
    fwd_sel_t         r_fwd_a;
    fwd_sel_t         r_fwd_b;
    fwd_sel_t         w_fwd_a;
    fwd_sel_t         w_fwd_b;
    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_flush_events;

    logic             w_flush;
    logic             w_ld_use;
    logic             w_unused_slot;

    riscv_dep_decode u_dec (
        .i_ir       (ifid_ir),
        .o_rs1      (w_rs1),
        .o_rs2      (w_rs2),
        .o_rd       (w_rd),
        .o_uses_rs1 (w_uses_rs1),
        .o_uses_rs2 (w_uses_rs2),
        .o_writes   (w_writes),
        .o_is_load  (w_is_load),
        .o_is_beq   (w_is_beq)
    );

    assign w_dec_slot = '{valid: 1'b1, rd: w_rd, writes: w_writes,
                          is_load: w_is_load, is_beq: w_is_beq};

    function automatic logic producer_hit(input slot_t s, input logic [REG_W-1:0] rs);
        return s.valid & s.writes & (s.rd == rs);
    endfunction

    // Youngest producer wins; operands the instruction does not read stay on the register path
    function automatic fwd_sel_t fwd_pick(input logic uses, input logic [REG_W-1:0] rs,
                                          input slot_t ex, input slot_t mem);
        fwd_sel_t sel;
        sel = FWD_REG;
        if (uses && producer_hit(ex, rs)) begin
            sel = FWD_EXMEM;
        end else if (uses && producer_hit(mem, rs)) begin
            sel = FWD_MEMWB;
        end
        return sel;
    endfunction

    assign w_fwd_a = fwd_pick(w_uses_rs1, w_rs1, r_ex, r_mem);
    assign w_fwd_b = fwd_pick(w_uses_rs2, w_rs2, r_ex, r_mem);

    // Branch flush outranks the load-use stall
    assign w_flush  = reset_n & r_ex.valid & r_ex.is_beq & branch_taken;
    assign w_ld_use = reset_n & ~w_flush & r_ex.valid & r_ex.is_load & r_ex.writes &
                      ((w_uses_rs1 & (w_rs1 == r_ex.rd)) | (w_uses_rs2 & (w_rs2 == r_ex.rd)));

    assign stall_pc    = w_ld_use;
    assign stall_ifid  = w_ld_use;
    assign bubble_idex = w_ld_use | w_flush;
    assign flush_ifid  = w_flush;

    // WB write and ID read share an edge, so ID takes the write-back value directly
    assign id_byp_a = reset_n & producer_hit(r_wb, w_rs1);
    assign id_byp_b = reset_n & producer_hit(r_wb, w_rs2);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_ex           <= '0;
            r_mem          <= '0;
            r_wb           <= '0;
            r_fwd_a        <= FWD_REG;
            r_fwd_b        <= FWD_REG;
            r_stall_cycles <= '0;
            r_flush_events <= '0;
        end else begin
            r_wb  <= r_mem;
            r_mem <= r_ex;
            if (bubble_idex) begin
                r_ex    <= '0;
                r_fwd_a <= FWD_REG;
                r_fwd_b <= FWD_REG;
            end else begin
                r_ex    <= w_dec_slot;
                r_fwd_a <= w_fwd_a;
                r_fwd_b <= w_fwd_b;
            end
            if (w_ld_use && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + CNT_W'(1);
            end
            if (w_flush && (r_flush_events != '1)) begin
                r_flush_events <= r_flush_events + CNT_W'(1);
            end
        end
    end

    assign fwd_a        = r_fwd_a;
    assign fwd_b        = r_fwd_b;
    assign stall_cycles = r_stall_cycles;
    assign flush_events = r_flush_events;

    assign w_unused_slot = ^{r_mem.is_load, r_mem.is_beq, r_wb.is_load, r_wb.is_beq};

endmodule
